// File: rtl/idecoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : idecoder_pipe
// Description : Registered RV32I/RV32M instruction decode stage. Decodes one
//               instruction word (plus its PC) per valid/ready beat and
//               presents the result one cycle later through a two-entry skid
//               buffer, so in_ready depends only on registered state. Keeps a
//               saturating count of illegal beats delivered downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module idecoder_pipe #(
    parameter int PC_WIDTH        = 32,
    parameter int ENABLE_M        = 1,
    parameter int ILL_CNT_WIDTH   = 16,
    parameter int INST_WIDTH      = 32,
    parameter int INST_TYPE_WIDTH = 4,
    parameter int IMM_WIDTH       = 32,
    parameter int REG_WIDTH       = 5,
    parameter int FUNCT_WIDTH     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_WIDTH-1:0]      in_inst,
    input  logic [PC_WIDTH-1:0]        in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [INST_TYPE_WIDTH-1:0] out_inst_type,
    output logic [IMM_WIDTH-1:0]       out_imm,
    output logic [REG_WIDTH-1:0]       out_rd,
    output logic [REG_WIDTH-1:0]       out_rs1,
    output logic [REG_WIDTH-1:0]       out_rs2,
    output logic [FUNCT_WIDTH-1:0]     out_funct,
    output logic                       out_illegal,
    output logic [ILL_CNT_WIDTH-1:0]   illegal_count
);

    // Instruction type codes; 0 is reserved for illegal beats.
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_NONE    = 4'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 4'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 4'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 4'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 4'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 4'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_LOAD    = 4'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 4'd7;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_AUIPC   = 4'd8;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JALR    = 4'd9;
    localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_FENCE   = 4'd10;

    // Function codes; 0 means "no function".
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NONE      = 5'd0;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD       = 5'd1;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB       = 5'd2;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL       = 5'd3;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT       = 5'd4;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLTU      = 5'd5;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_XOR       = 5'd6;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL       = 5'd7;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRA       = 5'd8;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR        = 5'd9;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND       = 5'd10;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_EQ        = 5'd11;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_NEQ       = 5'd12;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LT        = 5'd13;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTE       = 5'd14;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_LTU       = 5'd15;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_GTEU      = 5'd16;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTE  = 5'd17;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORD = 5'd18;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_WORD  = 5'd19;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_BYTEU = 5'd20;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MEM_HWORDU= 5'd21;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MUL       = 5'd22;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULH      = 5'd23;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULHSU    = 5'd24;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_MULHU     = 5'd25;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIV       = 5'd26;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_DIVU      = 5'd27;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_REM       = 5'd28;
    localparam logic [FUNCT_WIDTH-1:0] FUNCT_REMU      = 5'd29;

    // Major opcodes (bits [6:0]).
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_IMM    = 7'b0010011;
    localparam logic [6:0] c_OPC_REG    = 7'b0110011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [PC_WIDTH-1:0]        pc;
        logic [INST_TYPE_WIDTH-1:0] inst_type;
        logic [IMM_WIDTH-1:0]       imm;
        logic [REG_WIDTH-1:0]       rd;
        logic [REG_WIDTH-1:0]       rs1;
        logic [REG_WIDTH-1:0]       rs2;
        logic [FUNCT_WIDTH-1:0]     funct;
        logic                       illegal;
    } beat_t;

    logic       w_m_en;
    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_sh;
    logic        w_ill;
    beat_t       w_dec;
    logic        w_accept;

    beat_t r_main;
    logic  r_main_valid;
    beat_t r_skid;
    logic  r_skid_valid;
    logic [ILL_CNT_WIDTH-1:0] r_ill_cnt;

    if (ENABLE_M != 0) begin : g_m_on
        assign w_m_en = 1'b1;
    end else begin : g_m_off
        assign w_m_en = 1'b0;
    end

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];
    assign w_rd     = in_inst[11:7];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];

    assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_u  = {in_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_imm_sh = {27'b0, in_inst[24:20]};

    // Combinational decode of the incoming word; unused fields stay 0 and an
    // illegal encoding clears every decoded field except the PC.
    always_comb begin
        w_dec    = '0;
        w_ill    = 1'b0;
        w_dec.pc = in_pc;
        if (in_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opcode)
                c_OPC_LUI: begin
                    w_dec.inst_type = INST_TYPE_IMM;
                    w_dec.imm       = w_imm_u;
                    w_dec.rd        = w_rd;
                end
                c_OPC_AUIPC: begin
                    w_dec.inst_type = INST_TYPE_AUIPC;
                    w_dec.imm       = w_imm_u;
                    w_dec.rd        = w_rd;
                end
                c_OPC_JAL: begin
                    w_dec.inst_type = INST_TYPE_JAL;
                    w_dec.imm       = w_imm_j;
                    w_dec.rd        = w_rd;
                end
                c_OPC_JALR: begin
                    w_dec.inst_type = INST_TYPE_JALR;
                    w_dec.imm       = w_imm_i;
                    w_dec.rd        = w_rd;
                    w_dec.rs1       = w_rs1;
                    w_ill           = (w_f3 != 3'd0);
                end
                c_OPC_BRANCH: begin
                    w_dec.inst_type = INST_TYPE_BRANCH;
                    w_dec.imm       = w_imm_b;
                    w_dec.rs1       = w_rs1;
                    w_dec.rs2       = w_rs2;
                    case (w_f3)
                        3'd0:    w_dec.funct = FUNCT_EQ;
                        3'd1:    w_dec.funct = FUNCT_NEQ;
                        3'd4:    w_dec.funct = FUNCT_LT;
                        3'd5:    w_dec.funct = FUNCT_GTE;
                        3'd6:    w_dec.funct = FUNCT_LTU;
                        3'd7:    w_dec.funct = FUNCT_GTEU;
                        default: w_ill       = 1'b1;
                    endcase
                end
                c_OPC_LOAD: begin
                    w_dec.inst_type = INST_TYPE_LOAD;
                    w_dec.imm       = w_imm_i;
                    w_dec.rd        = w_rd;
                    w_dec.rs1       = w_rs1;
                    case (w_f3)
                        3'd0:    w_dec.funct = FUNCT_MEM_BYTE;
                        3'd1:    w_dec.funct = FUNCT_MEM_HWORD;
                        3'd2:    w_dec.funct = FUNCT_MEM_WORD;
                        3'd4:    w_dec.funct = FUNCT_MEM_BYTEU;
                        3'd5:    w_dec.funct = FUNCT_MEM_HWORDU;
                        default: w_ill       = 1'b1;
                    endcase
                end
                c_OPC_STORE: begin
                    w_dec.inst_type = INST_TYPE_STORE;
                    w_dec.imm       = w_imm_s;
                    w_dec.rs1       = w_rs1;
                    w_dec.rs2       = w_rs2;
                    case (w_f3)
                        3'd0:    w_dec.funct = FUNCT_MEM_BYTE;
                        3'd1:    w_dec.funct = FUNCT_MEM_HWORD;
                        3'd2:    w_dec.funct = FUNCT_MEM_WORD;
                        default: w_ill       = 1'b1;
                    endcase
                end
                c_OPC_IMM: begin
                    w_dec.inst_type = INST_TYPE_INT_IMM;
                    w_dec.imm       = w_imm_i;
                    w_dec.rd        = w_rd;
                    w_dec.rs1       = w_rs1;
                    case (w_f3)
                        3'd0: w_dec.funct = FUNCT_ADD;
                        3'd1: begin
                            w_dec.funct = FUNCT_SLL;
                            w_dec.imm   = w_imm_sh;
                            w_ill       = (w_f7 != c_F7_BASE);
                        end
                        3'd2: w_dec.funct = FUNCT_SLT;
                        3'd3: w_dec.funct = FUNCT_SLTU;
                        3'd4: w_dec.funct = FUNCT_XOR;
                        3'd5: begin
                            w_dec.imm   = w_imm_sh;
                            w_dec.funct = (w_f7 == c_F7_ALT) ? FUNCT_SRA : FUNCT_SRL;
                            w_ill       = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
                        end
                        3'd6: w_dec.funct = FUNCT_OR;
                        default: w_dec.funct = FUNCT_AND;
                    endcase
                end
                c_OPC_REG: begin
                    w_dec.inst_type = INST_TYPE_INT_REG;
                    w_dec.rd        = w_rd;
                    w_dec.rs1       = w_rs1;
                    w_dec.rs2       = w_rs2;
                    if (w_f7 == c_F7_BASE) begin
                        case (w_f3)
                            3'd0:    w_dec.funct = FUNCT_ADD;
                            3'd1:    w_dec.funct = FUNCT_SLL;
                            3'd2:    w_dec.funct = FUNCT_SLT;
                            3'd3:    w_dec.funct = FUNCT_SLTU;
                            3'd4:    w_dec.funct = FUNCT_XOR;
                            3'd5:    w_dec.funct = FUNCT_SRL;
                            3'd6:    w_dec.funct = FUNCT_OR;
                            default: w_dec.funct = FUNCT_AND;
                        endcase
                    end else if (w_f7 == c_F7_ALT) begin
                        case (w_f3)
                            3'd0:    w_dec.funct = FUNCT_SUB;
                            3'd5:    w_dec.funct = FUNCT_SRA;
                            default: w_ill       = 1'b1;
                        endcase
                    end else if ((w_f7 == c_F7_MULDIV) && w_m_en) begin
                        case (w_f3)
                            3'd0:    w_dec.funct = FUNCT_MUL;
                            3'd1:    w_dec.funct = FUNCT_MULH;
                            3'd2:    w_dec.funct = FUNCT_MULHSU;
                            3'd3:    w_dec.funct = FUNCT_MULHU;
                            3'd4:    w_dec.funct = FUNCT_DIV;
                            3'd5:    w_dec.funct = FUNCT_DIVU;
                            3'd6:    w_dec.funct = FUNCT_REM;
                            default: w_dec.funct = FUNCT_REMU;
                        endcase
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                c_OPC_FENCE: begin
                    // Only plain FENCE is supported; it carries no operands here.
                    w_dec.inst_type = INST_TYPE_FENCE;
                    w_ill           = (w_f3 != 3'd0);
                end
                default: w_ill = 1'b1;
            endcase
        end
        if (w_ill) begin
            w_dec.inst_type = INST_TYPE_NONE;
            w_dec.imm       = '0;
            w_dec.rd        = '0;
            w_dec.rs1       = '0;
            w_dec.rs2       = '0;
            w_dec.funct     = FUNCT_NONE;
        end
        w_dec.illegal = w_ill;
    end

    // The skid entry is the only thing that can block upstream.
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;

    // Two-entry skid buffer: main register feeds the outputs, skid catches the
    // one beat accepted while main is stalled. Main can never be empty while
    // skid is full, so skid always drains first and order is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    // Saturating count of illegal beats handed downstream; a delivery in a
    // flush cycle still counts because it completed at the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ill_cnt <= '0;
        end else if (r_main_valid && out_ready && r_main.illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign out_valid     = r_main_valid;
    assign out_pc        = r_main.pc;
    assign out_inst_type = r_main.inst_type;
    assign out_imm       = r_main.imm;
    assign out_rd        = r_main.rd;
    assign out_rs1       = r_main.rs1;
    assign out_rs2       = r_main.rs2;
    assign out_funct     = r_main.funct;
    assign out_illegal   = r_main.illegal;
    assign illegal_count = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idecoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_idecoder_pipe
// Description : Directed self-checking bench for idecoder_pipe. Three DUTs
//               share one stimulus: default build, ENABLE_M=0, and a 2-bit
//               illegal counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idecoder_pipe;

    localparam logic [3:0] T_NONE = 4'd0, T_IMM = 4'd1, T_INT_IMM = 4'd2, T_INT_REG = 4'd3,
                           T_BRANCH = 4'd4, T_STORE = 4'd5, T_LOAD = 4'd6, T_JAL = 4'd7,
                           T_AUIPC = 4'd8, T_JALR = 4'd9;
    localparam logic [4:0] F_NONE = 5'd0, F_ADD = 5'd1, F_SUB = 5'd2, F_SRA = 5'd8, F_EQ = 5'd11,
                           F_MEM_WORD = 5'd19, F_MEM_BYTEU = 5'd20, F_MUL = 5'd22;
    localparam logic [31:0] I_ADDI = 32'hFFF10093;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [3:0]  out_inst_type;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_funct;
    logic [15:0] illegal_count;

    logic        nm_in_ready, nm_out_valid, nm_out_illegal;
    logic [31:0] nm_out_pc, nm_out_imm;
    logic [3:0]  nm_out_inst_type;
    logic [4:0]  nm_out_rd, nm_out_rs1, nm_out_rs2, nm_out_funct;
    logic [15:0] nm_illegal_count;

    logic        c2_in_ready, c2_out_valid, c2_out_illegal;
    logic [31:0] c2_out_pc, c2_out_imm;
    logic [3:0]  c2_out_inst_type;
    logic [4:0]  c2_out_rd, c2_out_rs1, c2_out_rs2, c2_out_funct;
    logic [1:0]  c2_illegal_count;

    idecoder_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst_type(out_inst_type), .out_imm(out_imm), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct(out_funct), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    idecoder_pipe #(.ENABLE_M(0)) dut_nm (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
        .out_pc(nm_out_pc), .out_inst_type(nm_out_inst_type), .out_imm(nm_out_imm),
        .out_rd(nm_out_rd), .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2),
        .out_funct(nm_out_funct), .out_illegal(nm_out_illegal),
        .illegal_count(nm_illegal_count)
    );

    idecoder_pipe #(.ILL_CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c2_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(c2_out_valid), .out_ready(out_ready),
        .out_pc(c2_out_pc), .out_inst_type(c2_out_inst_type), .out_imm(c2_out_imm),
        .out_rd(c2_out_rd), .out_rs1(c2_out_rs1), .out_rs2(c2_out_rs2),
        .out_funct(c2_out_funct), .out_illegal(c2_out_illegal),
        .illegal_count(c2_illegal_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int exp_cnt_nm = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  typ;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  funct;
        logic        ill;
    } vec_t;

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL reset_out_imm: got %h expected 0", out_imm); end
        n_checks++; if (out_inst_type !== 4'h0) begin n_fail++; $display("FAIL reset_type: got %h expected 0", out_inst_type); end
        n_checks++; if (illegal_count !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", illegal_count); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h1000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_pc !== 32'h1000) begin n_fail++; $display("FAIL addi_pc: got %h expected 1000", out_pc); end
        n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h expected ffffffff", out_imm); end
        n_checks++; if (out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d expected 1", out_rd); end
        n_checks++; if (out_rs1 !== 5'd2) begin n_fail++; $display("FAIL addi_rs1: got %0d expected 2", out_rs1); end
        n_checks++; if (out_rs2 !== 5'd0) begin n_fail++; $display("FAIL addi_rs2: got %0d expected 0", out_rs2); end
        n_checks++; if (out_funct !== F_ADD) begin n_fail++; $display("FAIL addi_funct: got %0d expected %0d", out_funct, F_ADD); end
        n_checks++; if (out_inst_type !== T_INT_IMM) begin n_fail++; $display("FAIL addi_type: got %0d expected %0d", out_inst_type, T_INT_IMM); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal: got %b expected 0", out_illegal); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_shift();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h40525193; in_pc = 32'h1004; out_ready = 1'b1;
        @(negedge clk);
        in_inst = 32'h60525193; in_pc = 32'h1008;
        n_checks++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL srai_imm: got %h expected 5", out_imm); end
        n_checks++; if (out_rd !== 5'd3 || out_rs1 !== 5'd4) begin n_fail++; $display("FAIL srai_regs: got rd=%0d rs1=%0d expected rd=3 rs1=4", out_rd, out_rs1); end
        n_checks++; if (out_funct !== F_SRA || out_illegal !== 1'b0) begin n_fail++; $display("FAIL srai_funct: got %0d/%b expected %0d/0", out_funct, out_illegal, F_SRA); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL badsh_illegal: got %b expected 1", out_illegal); end
        n_checks++; if ({out_inst_type, out_imm, out_rd, out_rs1, out_funct} !== '0) begin n_fail++; $display("FAIL badsh_zero: got %h expected 0", {out_inst_type, out_imm, out_rd, out_rs1, out_funct}); end
        n_checks++; if (out_pc !== 32'h1008) begin n_fail++; $display("FAIL badsh_pc: got %h expected 1008", out_pc); end
        exp_cnt++; exp_cnt_nm++;
        @(negedge clk);
        n_checks++; if (illegal_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL badsh_count: got %0d expected %0d", illegal_count, exp_cnt); end
    endtask

    task automatic test_mul();
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'h027302B3; in_pc = 32'h2000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_funct !== F_MUL || out_inst_type !== T_INT_REG) begin n_fail++; $display("FAIL mul_funct: got %0d/%0d expected %0d/%0d", out_funct, out_inst_type, F_MUL, T_INT_REG); end
        n_checks++; if ({out_rd, out_rs1, out_rs2} !== {5'd5, 5'd6, 5'd7}) begin n_fail++; $display("FAIL mul_regs: got %0d,%0d,%0d expected 5,6,7", out_rd, out_rs1, out_rs2); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: got %b expected 0", out_illegal); end
        n_checks++; if (nm_out_illegal !== 1'b1 || nm_out_funct !== F_NONE || nm_out_inst_type !== T_NONE) begin n_fail++; $display("FAIL mul_nm_illegal: got %b/%0d/%0d expected 1/0/0", nm_out_illegal, nm_out_funct, nm_out_inst_type); end
        n_checks++; if (nm_illegal_count !== exp_cnt_nm[15:0]) begin n_fail++; $display("FAIL mul_nm_count_before: got %0d expected %0d", nm_illegal_count, exp_cnt_nm); end
        exp_cnt_nm++;
        @(negedge clk);
        n_checks++; if (nm_illegal_count !== exp_cnt_nm[15:0]) begin n_fail++; $display("FAIL mul_nm_count_after: got %0d expected %0d", nm_illegal_count, exp_cnt_nm); end
        n_checks++; if (illegal_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL mul_count: got %0d expected %0d", illegal_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        vec_t v [10];
        v[0] = '{32'h123452B7, T_IMM,     32'h12345000, 5'd5, 5'd0, 5'd0, F_NONE,       1'b0};
        v[1] = '{32'hFFDFF0EF, T_JAL,     32'hFFFFFFFC, 5'd1, 5'd0, 5'd0, F_NONE,       1'b0};
        v[2] = '{32'h00208463, T_BRANCH,  32'h00000008, 5'd0, 5'd1, 5'd2, F_EQ,         1'b0};
        v[3] = '{32'hFE20AE23, T_STORE,   32'hFFFFFFFC, 5'd0, 5'd1, 5'd2, F_MEM_WORD,   1'b0};
        v[4] = '{32'h01024183, T_LOAD,    32'h00000010, 5'd3, 5'd4, 5'd0, F_MEM_BYTEU,  1'b0};
        v[5] = '{32'h403100B3, T_INT_REG, 32'h00000000, 5'd1, 5'd2, 5'd3, F_SUB,        1'b0};
        v[6] = '{32'h00001397, T_AUIPC,   32'h00001000, 5'd7, 5'd0, 5'd0, F_NONE,       1'b0};
        v[7] = '{32'h00C280E7, T_JALR,    32'h0000000C, 5'd1, 5'd5, 5'd0, F_NONE,       1'b0};
        v[8] = '{32'h0020A463, T_NONE,    32'h00000000, 5'd0, 5'd0, 5'd0, F_NONE,       1'b1};
        v[9] = '{32'hFFF10090, T_NONE,    32'h00000000, 5'd0, 5'd0, 5'd0, F_NONE,       1'b1};
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (k > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * (k - 1)) ||
                    {out_inst_type, out_imm, out_rd, out_rs1, out_rs2, out_funct, out_illegal} !==
                    {v[k-1].typ, v[k-1].imm, v[k-1].rd, v[k-1].rs1, v[k-1].rs2, v[k-1].funct, v[k-1].ill}) begin
                    n_fail++;
                    $display("FAIL b2b_vec%0d: got v=%b pc=%h fields=%h expected pc=%h fields=%h", k - 1, out_valid, out_pc,
                             {out_inst_type, out_imm, out_rd, out_rs1, out_rs2, out_funct, out_illegal}, 32'h3000 + 32'(4 * (k - 1)),
                             {v[k-1].typ, v[k-1].imm, v[k-1].rd, v[k-1].rs1, v[k-1].rs2, v[k-1].funct, v[k-1].ill});
                end
            end
            if (k < 10) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b expected 1", k, in_ready); end
                in_valid = 1'b1; in_inst = v[k].inst; in_pc = 32'h3000 + 32'(4 * k);
            end else begin
                in_valid = 1'b0;
            end
        end
        exp_cnt += 2; exp_cnt_nm += 2;
        @(negedge clk);
        n_checks++; if (illegal_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", illegal_count, exp_cnt); end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got  = 0;
        in_inst = I_ADDI;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 4);
            in_pc     = 32'h4000 + 32'(4 * sent);
            if (c <= 2) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_c%0d: got %b expected 1", c, in_ready); end
            end
            if (c == 3 || c == 4) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, in_ready); end
                n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4000) begin n_fail++; $display("FAIL stall_hold_c%0d: got v=%b pc=%h expected v=1 pc=4000", c, out_valid, out_pc); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 4 || out_pc !== 32'h4000 + 32'(4 * got)) begin n_fail++; $display("FAIL stall_order%0d: got pc=%h expected %h", got, out_pc, 32'h4000 + 32'(4 * got)); end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL stall_delivered: got %0d expected 4", got); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h5000;
        @(negedge clk);
        in_pc = 32'h5004;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got in_ready=%b expected 0", in_ready); end
        in_pc = 32'h5008; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost: got v=%b pc=%h expected no beat", out_valid, out_pc); end
        end
        // Illegal beat delivered in the flush cycle, accepted beat dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'h5010;
        @(negedge clk);
        out_ready = 1'b1; in_inst = I_ADDI; in_pc = 32'h5014; flush = 1'b1;
        exp_cnt++; exp_cnt_nm++;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush2_empty: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        n_checks++; if (illegal_count !== exp_cnt[15:0]) begin n_fail++; $display("FAIL flush_count: got %0d expected %0d", illegal_count, exp_cnt); end
        @(negedge clk);
        in_valid = 1'b1; in_pc = 32'h5020;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h5020) begin n_fail++; $display("FAIL flush_resume: got v=%b pc=%h expected 1/5020", out_valid, out_pc); end
        @(negedge clk);
    endtask

    task automatic test_counter();
        logic [1:0] exp2 [5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inst = I_ADDI; in_pc = 32'h6000;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset: got v=%b rdy=%b expected 0/1", out_valid, in_ready); end
        n_checks++; if (illegal_count !== 16'h0 || c2_illegal_count !== 2'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d/%0d expected 0/0", illegal_count, c2_illegal_count); end
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'h7000 + 32'(4 * k);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (c2_illegal_count !== exp2[k]) begin n_fail++; $display("FAIL sat_count%0d: got %0d expected %0d", k, c2_illegal_count, exp2[k]); end
            n_checks++; if (illegal_count !== 16'(k + 1)) begin n_fail++; $display("FAIL wide_count%0d: got %0d expected %0d", k, illegal_count, k + 1); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_shift();
        test_mul();
        test_back_to_back();
        test_stall();
        test_flush();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
